// File: rtl/io_bus_master_pkg.sv
// Shared constants, FSM states and alignment helper for the IO bus initiator.
// Optional feature macro: IO_BUS_ALIGN_CHECK_EN (adds the ERR state).
package io_bus_master_pkg;

  localparam int IO_BUS_WIDTH_ADDR = 32;
  localparam int IO_BUS_WIDTH_DATA = 32;
  localparam int IO_BUS_WIDTH_CTRL = 4;

  // ctrl bit positions; IO_CTRL_SIZE is the LSB of the 2-bit size field
  localparam int IO_CTRL_RD   = 0;
  localparam int IO_CTRL_WR   = 1;
  localparam int IO_CTRL_SIZE = 2;

  localparam logic [1:0] IO_SIZE_BYTE = 2'b00;
  localparam logic [1:0] IO_SIZE_HALF = 2'b01;
  localparam logic [1:0] IO_SIZE_WORD = 2'b10;

  localparam logic [19:0] IO_DEV_PREFIX = 20'hFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_RELEASE = 3'd3
`ifdef IO_BUS_ALIGN_CHECK_EN
    ,
    ST_ERR     = 3'd4
`endif
  } state_e;

`ifdef IO_BUS_ALIGN_CHECK_EN
  // Size codes 10 and 11 are both word accesses
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == IO_SIZE_HALF) && off[0]) || (size[1] && (off != 2'b00));
  endfunction
`endif

endpackage

// File: rtl/io_bus_master_if.sv
// CPU request/response and bus address/control signals of the IO bus initiator.
// The bidirectional data bus stays a plain module port so the tristate net is resolved at the top.
interface io_bus_master_if
  import io_bus_master_pkg::*;
#(
  parameter int ADDR_W = IO_BUS_WIDTH_ADDR,
  parameter int DATA_W = IO_BUS_WIDTH_DATA,
  parameter int CTRL_W = IO_BUS_WIDTH_CTRL
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_size;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;
  logic              BC;
  logic [ADDR_W-1:0] addr;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_done, cpu_rdata, cpu_err, BC, addr, ctrl
  );

  modport slave (
    output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_done, cpu_rdata, cpu_err, BC, addr, ctrl
  );

endinterface

// File: rtl/io_bus_master_lane_align.sv
// Combinational lane steering: store-data replication onto all lanes and
// load-data shift/mask/zero-extend from the addressed byte lane.
module io_bus_lane_align
  import io_bus_master_pkg::*;
#(
  parameter int DATA_W = IO_BUS_WIDTH_DATA
) (
  input  logic [1:0]        size,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int NB = DATA_W / 8;
  localparam int NH = DATA_W / 16;

  logic [DATA_W-1:0] shifted;

  always_comb begin
    bus_wdata = wdata;
    case (size)
      IO_SIZE_BYTE: bus_wdata = {NB{wdata[7:0]}};
      IO_SIZE_HALF: bus_wdata = {NH{wdata[15:0]}};
      default:      bus_wdata = wdata;
    endcase

    shifted = bus_rdata >> {byte_off, 3'b000};
    case (size)
      IO_SIZE_BYTE: rdata = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      IO_SIZE_HALF: rdata = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default:      rdata = shifted;
    endcase
  end

endmodule

// File: rtl/io_bus_master.sv
// IO bus initiator: one CPU request at a time, IDLE->ADDR->ACCESS(xLAT)->RELEASE.
// Optional feature macro: IO_BUS_ALIGN_CHECK_EN rejects misaligned accesses via a one-cycle ERR state.
module io_bus_master
  import io_bus_master_pkg::*;
#(
  parameter int ADDR_W  = IO_BUS_WIDTH_ADDR,
  parameter int DATA_W  = IO_BUS_WIDTH_DATA,
  parameter int CTRL_W  = IO_BUS_WIDTH_CTRL,
  parameter int RAM_LAT = 2,
  parameter int DEV_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  io_bus_master_if.master   bus,
  inout  wire  [DATA_W-1:0] data
);

  localparam int LAT_MAX = (RAM_LAT > DEV_LAT) ? RAM_LAT : DEV_LAT;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] rd_aligned;
  logic              data_oe;
  logic              accept;
  logic              dev_hit;
  logic              last_access;
  logic [CNT_W-1:0]  lat_m1;

  assign accept      = (state == ST_IDLE) && bus.cpu_req;
  assign dev_hit     = (req_addr[ADDR_W-1 -: 20] == IO_DEV_PREFIX);
  assign lat_m1      = dev_hit ? CNT_W'(DEV_LAT - 1) : CNT_W'(RAM_LAT - 1);
  assign last_access = (state == ST_ACCESS) && (cnt == '0);

  io_bus_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .size      (req_size),
    .byte_off  (req_addr[1:0]),
    .wdata     (req_wdata),
    .bus_rdata (data),
    .bus_wdata (bus_wdata),
    .rdata     (rd_aligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (last_access && !req_we) rdata_q <= rd_aligned;
    end
  end

  // Request capture: only the accept edge loads, so held or changing inputs are ignored later
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we    <= bus.cpu_we;
      req_size  <= bus.cpu_size;
      req_addr  <= bus.cpu_addr;
      req_wdata <= bus.cpu_wdata;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bus.cpu_ready = 1'b0;
    bus.cpu_done  = 1'b0;
    bus.BC        = 1'b0;
    bus.addr      = '0;
    bus.ctrl      = '0;
    data_oe       = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.cpu_ready = 1'b1;
        if (bus.cpu_req) begin
`ifdef IO_BUS_ALIGN_CHECK_EN
          state_nxt = is_misaligned(bus.cpu_size, bus.cpu_addr[1:0]) ? ST_ERR : ST_ADDR;
`else
          state_nxt = ST_ADDR;
`endif
        end
      end
      ST_ADDR: begin
        bus.BC                       = 1'b1;
        bus.addr                     = req_addr;
        bus.ctrl[IO_CTRL_SIZE +: 2]  = req_size;
        data_oe                      = req_we;
        cnt_nxt                      = lat_m1;
        state_nxt                    = ST_ACCESS;
      end
      ST_ACCESS: begin
        bus.BC                       = 1'b1;
        bus.addr                     = req_addr;
        bus.ctrl[IO_CTRL_SIZE +: 2]  = req_size;
        bus.ctrl[IO_CTRL_RD]         = !req_we;
        bus.ctrl[IO_CTRL_WR]         = req_we;
        data_oe                      = req_we;
        if (cnt == '0) state_nxt = ST_RELEASE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_RELEASE: begin
        // Bus still owned for one cycle with the address held, strobes and data released
        bus.BC                       = 1'b1;
        bus.addr                     = req_addr;
        bus.ctrl[IO_CTRL_SIZE +: 2]  = req_size;
        bus.cpu_done                 = 1'b1;
        state_nxt                    = ST_IDLE;
      end
`ifdef IO_BUS_ALIGN_CHECK_EN
      ST_ERR: begin
        bus.cpu_done = 1'b1;
        state_nxt    = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign data          = data_oe ? bus_wdata : {DATA_W{1'bz}};
  assign bus.cpu_rdata = rdata_q;

`ifdef IO_BUS_ALIGN_CHECK_EN
  assign bus.cpu_err = (state == ST_ERR);
`else
  assign bus.cpu_err = 1'b0;
`endif

endmodule
